// File: rtl/system_ram_arbiter.sv
// system_ram_arbiter: two-master (instruction fetch m0, data m1) arbiter and sequencer in
// front of the single SystemRam port. Each access takes IDLE -> ACCESS -> DONE.
// Defining SYSTEM_RAM_ARBITER_STATS_EN adds saturating grant/conflict counters.
module system_ram_arbiter #(
   parameter int unsigned ADDR_WIDTH     = 28,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter bit          FIXED_PRIORITY = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     m0_address,
   input  logic                      m0_read,
   input  logic                      m0_write,
   input  logic [DATA_WIDTH-1:0]     m0_writedata,
   input  logic [DATA_WIDTH/8-1:0]   m0_byteenable,
   output logic [DATA_WIDTH-1:0]     m0_readdata,
   output logic                      m0_waitrequest,
   input  logic [ADDR_WIDTH-1:0]     m1_address,
   input  logic                      m1_read,
   input  logic                      m1_write,
   input  logic [DATA_WIDTH-1:0]     m1_writedata,
   input  logic [DATA_WIDTH/8-1:0]   m1_byteenable,
   output logic [DATA_WIDTH-1:0]     m1_readdata,
   output logic                      m1_waitrequest,
   output logic [ADDR_WIDTH-1:0]     ram_address,
   output logic                      ram_read,
   output logic                      ram_write,
   output logic [DATA_WIDTH-1:0]     ram_writedata,
   output logic [DATA_WIDTH/8-1:0]   ram_byteenable,
   input  logic [DATA_WIDTH-1:0]     ram_readdata
`ifdef SYSTEM_RAM_ARBITER_STATS_EN
   ,
   output logic [31:0]               m0_grant_count,
   output logic [31:0]               m1_grant_count,
   output logic [31:0]               conflict_count
`endif
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

   state_t state_q;
   logic   grant_q;   // master owning the current access (1 = m1)
   logic   last_q;    // master granted by the previous completed access (1 = m1)
   logic   req0;
   logic   req1;
   logic   pick1;

   // Request decode and arbitration winner for the current IDLE cycle
   always_comb begin
      req0 = m0_read | m0_write;
      req1 = m1_read | m1_write;
      if (req0 && req1) begin
         pick1 = FIXED_PRIORITY ? 1'b0 : ~last_q;
      end else begin
         pick1 = req1;
      end
   end

   // Access sequencer: latch winner into the RAM port, strobe for one cycle, then complete
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         grant_q        <= 1'b0;
         last_q         <= 1'b1;
         ram_address    <= '0;
         ram_read       <= 1'b0;
         ram_write      <= 1'b0;
         ram_writedata  <= '0;
         ram_byteenable <= '0;
         m0_readdata    <= '0;
         m1_readdata    <= '0;
         m0_waitrequest <= 1'b1;
         m1_waitrequest <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req0 || req1) begin
                  grant_q        <= pick1;
                  ram_address    <= pick1 ? m1_address    : m0_address;
                  ram_writedata  <= pick1 ? m1_writedata  : m0_writedata;
                  ram_byteenable <= pick1 ? m1_byteenable : m0_byteenable;
                  // Read with write asserted is treated as a plain write
                  ram_write      <= pick1 ? m1_write : m0_write;
                  ram_read       <= pick1 ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
                  state_q        <= StAccess;
               end
            end
            StAccess: begin
               // RAM data is only valid while ram_read is held, so capture at this edge
               if (ram_read) begin
                  if (grant_q) begin
                     m1_readdata <= ram_readdata;
                  end else begin
                     m0_readdata <= ram_readdata;
                  end
               end
               ram_read  <= 1'b0;
               ram_write <= 1'b0;
               if (grant_q) begin
                  m1_waitrequest <= 1'b0;
               end else begin
                  m0_waitrequest <= 1'b0;
               end
               state_q <= StDone;
            end
            StDone: begin
               m0_waitrequest <= 1'b1;
               m1_waitrequest <= 1'b1;
               last_q         <= grant_q;
               state_q        <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef SYSTEM_RAM_ARBITER_STATS_EN
   // Saturating usage counters: grants counted on completion, conflicts per contended IDLE cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m0_grant_count <= '0;
         m1_grant_count <= '0;
         conflict_count <= '0;
      end else begin
         if (state_q == StDone && !grant_q && m0_grant_count != 32'hFFFF_FFFF) begin
            m0_grant_count <= m0_grant_count + 32'd1;
         end
         if (state_q == StDone && grant_q && m1_grant_count != 32'hFFFF_FFFF) begin
            m1_grant_count <= m1_grant_count + 32'd1;
         end
         if (state_q == StIdle && req0 && req1 && conflict_count != 32'hFFFF_FFFF) begin
            conflict_count <= conflict_count + 32'd1;
         end
      end
   end
`endif

endmodule
